// File: rtl/dac_frame_spi_tx.sv
// dac_frame_spi_tx: formats 8-bit samples into 16-bit DAC command frames and sends them over SPI mode 0 with an LDAC pulse
module dac_frame_spi_tx #(
  parameter int         CLK_DIV = 2,
  parameter logic [3:0] CONFIG  = 4'b0011
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_in_valid_strobe_i,
  output logic       spi_clk_o,
  output logic       spi_mosi_o,
  output logic       spi_cs_o,
  output logic       dac_ldac_o,
  output logic       busy_o,
  output logic       overrun_strobe_o
);
  localparam int CW = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_STOP, S_LDAC} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_pend;
  logic          r_pend_v;
  logic          r_arm;
  logic [14:0]   r_sh;
  logic [4:0]    r_bit;
  logic          r_ph;
  logic          w_end;
  logic          w_consume;

  assign w_end = r_cnt == LAST;
  // pending is taken either one cycle after IDLE notices it, or straight out of the last LDAC cycle
  assign w_consume = (r_state == S_IDLE && r_arm) || (r_state == S_LDAC && w_end && r_pend_v);

  // one-deep pending sample; a strobe on the consumption cycle stays pending and is not an overrun
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pend           <= '0;
      r_pend_v         <= 1'b0;
      overrun_strobe_o <= 1'b0;
    end else begin
      r_pend           <= data_in_valid_strobe_i ? data_i : r_pend;
      r_pend_v         <= data_in_valid_strobe_i | (r_pend_v & ~w_consume);
      overrun_strobe_o <= data_in_valid_strobe_i & r_pend_v & ~w_consume;
    end
  end

  // frame sequencer with registered SPI/LDAC outputs; r_bit wraps to 31 once bit0's high phase is done
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_arm      <= 1'b0;
      r_sh       <= '0;
      r_bit      <= '0;
      r_ph       <= 1'b0;
      spi_cs_o   <= 1'b1;
      spi_clk_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      dac_ldac_o <= 1'b1;
      busy_o     <= 1'b0;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_end) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: r_arm <= r_pend_v;
        S_START: if (w_end) begin
          r_state   <= S_SHIFT;
          spi_clk_o <= 1'b1;
          r_ph      <= 1'b1;
        end
        S_SHIFT: if (w_end) begin
          if (r_ph) begin
            spi_clk_o <= 1'b0;
            r_ph      <= 1'b0;
            r_bit     <= r_bit - 5'd1;
            if (r_bit != 5'd0) begin
              r_sh       <= {r_sh[13:0], 1'b0};
              spi_mosi_o <= r_sh[14];
            end
          end else if (r_bit == 5'd31) begin
            r_state    <= S_STOP;
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
          end else begin
            spi_clk_o <= 1'b1;
            r_ph      <= 1'b1;
          end
        end
        S_STOP: if (w_end) begin
          r_state    <= S_LDAC;
          dac_ldac_o <= 1'b0;
        end
        S_LDAC: if (w_end) begin
          r_state    <= S_IDLE;
          dac_ldac_o <= 1'b1;
          busy_o     <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_consume) begin
        r_state    <= S_START;
        r_arm      <= 1'b0;
        r_sh       <= {CONFIG[2:0], r_pend, 4'b0000};
        r_bit      <= 5'd15;
        spi_mosi_o <= CONFIG[3];
        spi_cs_o   <= 1'b0;
        busy_o     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dac_frame_spi_tx.sv
// tb_dac_frame_spi_tx: directed vectors plus multi-cycle corner sequences for dac_frame_spi_tx
module tb_dac_frame_spi_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] stb = 2'b00;
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;
  logic [1:0] sck, mosi, cs, ldac, busy, ovr;
  logic       mon_clr = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         s_cyc = 0;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] w;
  } vec_t;
  vec_t tbl [6];

  int          nf [2], ne [2], cs_run [2], hi_run [2], busy_run [2], ldac_run [2];
  int          last_cs [2], last_gap [2], last_busy [2], last_ldac [2], fall_cyc [2], ovr_n [2];
  logic [15:0] sh [2];
  logic [15:0] fw [2][16];
  int          fe [2][16];
  logic [1:0]  p_sck = 2'b00, p_cs = 2'b11, p_busy = 2'b00, p_ldac = 2'b11;

  dac_frame_spi_tx #(.CLK_DIV(2)) u_h2 (
    .clk_i(clk), .rst_i(rst_n), .data_i(din0), .data_in_valid_strobe_i(stb[0]),
    .spi_clk_o(sck[0]), .spi_mosi_o(mosi[0]), .spi_cs_o(cs[0]), .dac_ldac_o(ldac[0]),
    .busy_o(busy[0]), .overrun_strobe_o(ovr[0])
  );
  dac_frame_spi_tx #(.CLK_DIV(1)) u_h1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(din1), .data_in_valid_strobe_i(stb[1]),
    .spi_clk_o(sck[1]), .spi_mosi_o(mosi[1]), .spi_cs_o(cs[1]), .dac_ldac_o(ldac[1]),
    .busy_o(busy[1]), .overrun_strobe_o(ovr[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // frame decoder and pulse-width meter for both instances
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mon_clr) begin
        nf[k] = 0; ne[k] = 0; sh[k] = 16'h0; cs_run[k] = 0; hi_run[k] = 0; busy_run[k] = 0;
        ldac_run[k] = 0; last_cs[k] = 0; last_gap[k] = 0; last_busy[k] = 0; last_ldac[k] = 0;
        fall_cyc[k] = 0; ovr_n[k] = 0;
      end else begin
        if (sck[k] && !p_sck[k]) begin
          sh[k] = {sh[k][14:0], mosi[k]};
          ne[k]++;
        end
        if (!cs[k]) cs_run[k]++;
        if (!cs[k] && p_cs[k]) begin
          fall_cyc[k] = cyc;
          last_gap[k] = hi_run[k];
        end
        if (cs[k] && !p_cs[k]) begin
          last_cs[k] = cs_run[k];
          cs_run[k] = 0;
          if (nf[k] < 16) begin
            fw[k][nf[k]] = sh[k];
            fe[k][nf[k]] = ne[k];
          end
          nf[k]++;
          sh[k] = 16'h0;
          ne[k] = 0;
        end
        hi_run[k] = (busy[k] && cs[k]) ? hi_run[k] + 1 : 0;
        if (busy[k]) busy_run[k]++;
        if (!busy[k] && p_busy[k]) begin
          last_busy[k] = busy_run[k];
          busy_run[k] = 0;
        end
        if (!ldac[k]) ldac_run[k]++;
        if (ldac[k] && !p_ldac[k]) begin
          last_ldac[k] = ldac_run[k];
          ldac_run[k] = 0;
        end
        if (ovr[k]) ovr_n[k]++;
      end
    end
    p_sck = sck; p_cs = cs; p_busy = busy; p_ldac = ldac;
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic clr();
    @(negedge clk); #1 mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    @(negedge clk);
    if (k == 0) din0 = d; else din1 = d;
    stb[k] = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    stb[k] = 1'b0;
    if (k == 0) din0 = ~d; else din1 = ~d;
  endtask

  task automatic wait_done(input int k, input int n, input int budget);
    int i = 0;
    while (!(nf[k] >= n && !busy[k]) && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk("frame_timeout", (nf[k] >= n && !busy[k]) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int i;
    tbl[0] = '{8'hA5, 16'h3A50};
    tbl[1] = '{8'h00, 16'h3000};
    tbl[2] = '{8'hFF, 16'h3FF0};
    tbl[3] = '{8'h5A, 16'h35A0};
    tbl[4] = '{8'h81, 16'h3810};
    tbl[5] = '{8'h3C, 16'h33C0};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs", cs[0], 1);
    chk("rst_sck", sck[0], 0);
    chk("rst_ldac", ldac[0], 1);
    chk("rst_busy", busy[0], 0);
    @(negedge clk) rst_n = 1'b1;
    clr();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (cs != 2'b11 || sck != 2'b00 || mosi != 2'b00 || ldac != 2'b11 || busy != 2'b00 || ovr != 2'b00) bad++;
    end
    chk("idle_outputs", bad, 0);

    for (int v = 0; v < 6; v++) begin
      clr();
      send(0, tbl[v].d);
      wait_done(0, 1, 300);
      chk("vec_word", fw[0][0], tbl[v].w);
      chk("vec_edges", fe[0][0], 16);
      chk("vec_cs_low", last_cs[0], 66);
      chk("vec_busy", last_busy[0], 70);
      chk("vec_ldac", last_ldac[0], 2);
      chk("vec_latency", fall_cyc[0] - s_cyc, 3);
      chk("vec_frames", nf[0], 1);
      chk("vec_overrun", ovr_n[0], 0);
    end

    clr();
    send(1, 8'h00);
    repeat (8) @(negedge clk);
    send(1, 8'hFF);
    wait_done(1, 2, 300);
    chk("b2b_word0", fw[1][0], 16'h3000);
    chk("b2b_word1", fw[1][1], 16'h3FF0);
    chk("b2b_gap", last_gap[1], 2);
    chk("b2b_busy", last_busy[1], 70);
    chk("b2b_cs_low", last_cs[1], 33);
    chk("b2b_overrun", ovr_n[1], 0);

    clr();
    send(0, 8'h11);
    repeat (18) @(negedge clk);
    send(0, 8'h22);
    repeat (18) @(negedge clk);
    send(0, 8'h33);
    wait_done(0, 2, 400);
    repeat (80) @(negedge clk);
    #1;
    chk("ovr_word0", fw[0][0], 16'h3110);
    chk("ovr_word1", fw[0][1], 16'h3330);
    chk("ovr_frames", nf[0], 2);
    chk("ovr_count", ovr_n[0], 1);

    clr();
    @(negedge clk);
    din0 = 8'h42; stb[0] = 1'b1;
    @(negedge clk);
    stb[0] = 1'b0; din0 = 8'h00;
    @(negedge clk);
    din0 = 8'h99; stb[0] = 1'b1;
    @(negedge clk);
    stb[0] = 1'b0; din0 = 8'h00;
    wait_done(0, 2, 400);
    chk("cons_word0", fw[0][0], 16'h3420);
    chk("cons_word1", fw[0][1], 16'h3990);
    chk("cons_gap", last_gap[0], 4);
    chk("cons_overrun", ovr_n[0], 0);

    clr();
    send(0, 8'h24);
    i = 0;
    while (ldac[0] && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    chk("ldac_seen", ldac[0], 0);
    @(negedge clk);
    din0 = 8'hE7; stb[0] = 1'b1;
    @(negedge clk);
    stb[0] = 1'b0; din0 = 8'h00;
    wait_done(0, 2, 400);
    chk("ldac_word0", fw[0][0], 16'h3240);
    chk("ldac_word1", fw[0][1], 16'h3E70);
    chk("ldac_overrun", ovr_n[0], 0);

    clr();
    send(0, 8'hCB);
    repeat (4) @(negedge clk);
    send(0, 8'h77);
    i = 0;
    while (ne[0] < 9 && i < 200) begin
      @(negedge clk); #1;
      i++;
    end
    chk("mid_edges", ne[0], 9);
    chk("mid_sck_high", sck[0], 1);
    chk("mid_mosi_bit7", mosi[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs", cs[0], 1);
    chk("arst_sck", sck[0], 0);
    chk("arst_mosi", mosi[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_ldac", ldac[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (busy[0] || !cs[0]) bad++;
    end
    chk("arst_pending_cleared", bad, 0);
    send(0, 8'h5A);
    wait_done(0, 1, 300);
    chk("arst_word", fw[0][0], 16'h35A0);
    chk("arst_edges", fe[0][0], 16);
    chk("arst_frames", nf[0], 1);
    chk("arst_overrun", ovr_n[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
